complex_mult_param: RTL and testbench



---
 rtl/complex_mult_param_if.sv | 37 +++
 rtl/complex_mult_param.sv | 183 ++++++++++++++++++
 tb/tb_complex_mult_param.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/complex_mult_param_if.sv
`default_nettype none
// ============================================================================
// Module      : complex_mult_param_if
// Description : Operand/result handshake bundle for complex_mult_param.
//               master : operand producer and result consumer
//               slave  : the multiplier
// Ports       : op_val/op_ready/conj_en/op_1_*/op_2_* (operand side)
//               res_val/res_ready/res_re/res_im (result side), busy
// Revision    : 1.0  initial release
// ============================================================================
interface complex_mult_param_if #(
    parameter int DATA_WIDTH = 8
);
    logic                           op_val;
    logic                           op_ready;
    logic                           conj_en;
    logic signed [DATA_WIDTH-1:0]   op_1_re;
    logic signed [DATA_WIDTH-1:0]   op_1_im;
    logic signed [DATA_WIDTH-1:0]   op_2_re;
    logic signed [DATA_WIDTH-1:0]   op_2_im;
    logic                           res_val;
    logic                           res_ready;
    logic signed [2*DATA_WIDTH:0]   res_re;
    logic signed [2*DATA_WIDTH:0]   res_im;
    logic                           busy;

    modport master (
        output op_val, conj_en, op_1_re, op_1_im, op_2_re, op_2_im, res_ready,
        input  op_ready, res_val, res_re, res_im, busy
    );

    modport slave (
        input  op_val, conj_en, op_1_re, op_1_im, op_2_re, op_2_im, res_ready,
        output op_ready, res_val, res_re, res_im, busy
    );
endinterface
`default_nettype wire

// File: rtl/complex_mult_param.sv
`default_nettype none
// ============================================================================
// Module      : complex_mult_param
// Description : Sequential complex multiplier (a+bj)*(c+dj), optionally
//               (a+bj)*conj(c+dj). NUM_MULT real multipliers are shared over
//               K = 4/NUM_MULT multiply cycles, then one compute cycle.
// Ports       : clk    - clock, rising edge
//               sw_rst - synchronous active-high reset
//               bus    - handshake bundle (slave side)
// Parameters  : DATA_WIDTH (2..32), NUM_MULT (1, 2 or 4)
// Revision    : 1.0  initial release
// ============================================================================
module complex_mult_param #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_MULT   = 2
) (
    input  wire                    clk,
    input  wire                    sw_rst,
    complex_mult_param_if.slave    bus
);

    localparam int        c_PW     = 2 * DATA_WIDTH;       // product width
    localparam int        c_RW     = 2 * DATA_WIDTH + 1;   // result width
    localparam int        c_K      = 4 / NUM_MULT;
    localparam logic [1:0] c_CNT_LAST = 2'(c_K - 1);

    // ------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------
    if (!(NUM_MULT == 1 || NUM_MULT == 2 || NUM_MULT == 4)) begin : g_bad_num_mult
        $error("complex_mult_param: NUM_MULT must be 1, 2 or 4");
    end
    if (DATA_WIDTH < 2 || DATA_WIDTH > 32) begin : g_bad_data_width
        $error("complex_mult_param: DATA_WIDTH must be in 2..32");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MULT     = 2'd1,
        S_COMPUTE  = 2'd2,
        S_WAIT_RES = 2'd3
    } state_t;

    state_t                       r_state;
    state_t                       w_next_state;
    logic [1:0]                   r_cnt;
    logic signed [DATA_WIDTH-1:0] r_a;
    logic signed [DATA_WIDTH-1:0] r_b;
    logic signed [DATA_WIDTH-1:0] r_c;
    logic signed [DATA_WIDTH-1:0] r_d;
    logic                         r_conj;
    logic signed [c_PW-1:0]       r_prod [4];   // P0=a*c P1=b*d P2=b*c P3=a*d
    logic signed [c_RW-1:0]       r_res_re;
    logic signed [c_RW-1:0]       r_res_im;

    logic                         w_op_ready;
    logic                         w_op_hs;
    logic [1:0]                   w_lane_sel  [NUM_MULT];
    logic signed [c_PW-1:0]       w_lane_prod [NUM_MULT];
    logic signed [c_RW-1:0]       w_p_ext     [4];
    logic signed [c_RW-1:0]       w_re;
    logic signed [c_RW-1:0]       w_im;

    // ------------------------------------------------------------------
    // Handshake. op_ready is combinational on res_ready so a result can be
    // consumed and new operands accepted on the same edge (no bubble).
    // ------------------------------------------------------------------
    assign w_op_ready = (r_state == S_IDLE) ||
                        ((r_state == S_WAIT_RES) && bus.res_ready);
    assign w_op_hs    = bus.op_val && w_op_ready;

    assign bus.op_ready = w_op_ready;
    assign bus.res_val  = (r_state == S_WAIT_RES);
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.res_re   = r_res_re;
    assign bus.res_im   = r_res_im;

    // ------------------------------------------------------------------
    // Multiplier lanes. Lane i in multiply cycle n produces product index
    // n*NUM_MULT + i, giving the P0,P1,P2,P3 ordering for every NUM_MULT.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_MULT; gi++) begin : g_lane
        logic [1:0]                   w_sel;
        logic signed [DATA_WIDTH-1:0] w_x;
        logic signed [DATA_WIDTH-1:0] w_y;
        logic signed [c_PW-1:0]       w_xe;
        logic signed [c_PW-1:0]       w_ye;

        assign w_sel = 2'(int'(r_cnt) * NUM_MULT + gi);
        // a is used by P0 and P3, c by P0 and P2
        assign w_x   = (w_sel == 2'd0 || w_sel == 2'd3) ? r_a : r_b;
        assign w_y   = (w_sel == 2'd0 || w_sel == 2'd2) ? r_c : r_d;
        // Full-width operands: the 2*DATA_WIDTH product is exact
        assign w_xe  = {{DATA_WIDTH{w_x[DATA_WIDTH-1]}}, w_x};
        assign w_ye  = {{DATA_WIDTH{w_y[DATA_WIDTH-1]}}, w_y};

        assign w_lane_sel[gi]  = w_sel;
        assign w_lane_prod[gi] = w_xe * w_ye;
    end

    // ------------------------------------------------------------------
    // Final add/subtract on sign-extended products; cannot overflow.
    // ------------------------------------------------------------------
    for (genvar gp = 0; gp < 4; gp++) begin : g_ext
        assign w_p_ext[gp] = {r_prod[gp][c_PW-1], r_prod[gp]};
    end

    assign w_re = r_conj ? (w_p_ext[0] + w_p_ext[1]) : (w_p_ext[0] - w_p_ext[1]);
    assign w_im = r_conj ? (w_p_ext[2] - w_p_ext[3]) : (w_p_ext[2] + w_p_ext[3]);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_op_hs) w_next_state = S_MULT;
            end
            S_MULT: begin
                if (r_cnt == c_CNT_LAST) w_next_state = S_COMPUTE;
            end
            S_COMPUTE: begin
                w_next_state = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                if (bus.res_ready) w_next_state = w_op_hs ? S_MULT : S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (sw_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 2'd0;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_d      <= '0;
            r_conj   <= 1'b0;
            r_res_re <= '0;
            r_res_im <= '0;
            for (int j = 0; j < 4; j++) begin
                r_prod[j] <= '0;
            end
        end else begin
            r_state <= w_next_state;

            if (w_op_hs) begin
                r_a    <= bus.op_1_re;
                r_b    <= bus.op_1_im;
                r_c    <= bus.op_2_re;
                r_d    <= bus.op_2_im;
                r_conj <= bus.conj_en;
                r_cnt  <= 2'd0;
            end else if (r_state == S_MULT) begin
                r_cnt <= r_cnt + 2'd1;
            end

            if (r_state == S_MULT) begin
                for (int i = 0; i < NUM_MULT; i++) begin
                    r_prod[w_lane_sel[i]] <= w_lane_prod[i];
                end
            end

            if (r_state == S_COMPUTE) begin
                r_res_re <= w_re;
                r_res_im <= w_im;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_complex_mult_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_complex_mult_param
// Description : Self-checking bench for complex_mult_param. Three instances
//               (NUM_MULT = 1, 2, 4) share clock, reset and operand data;
//               each has its own op_val and res_ready.
// Revision    : 1.0  initial release
// ============================================================================
module tb_complex_mult_param;

    localparam int DW = 8;

    logic clk;
    logic sw_rst;
    logic [2:0] op_val;
    logic [2:0] res_ready;
    logic conj_en;
    logic signed [DW-1:0] a, b, c, d;

    logic [2:0] o_rv, o_rdy, o_busy;
    logic signed [2*DW:0] o_re [3];
    logic signed [2*DW:0] o_im [3];

    int checks = 0;
    int errors = 0;

    complex_mult_param_if #(.DATA_WIDTH(DW)) u_if1 ();
    complex_mult_param_if #(.DATA_WIDTH(DW)) u_if2 ();
    complex_mult_param_if #(.DATA_WIDTH(DW)) u_if4 ();

    assign u_if1.op_val = op_val[0];    assign u_if1.res_ready = res_ready[0];
    assign u_if2.op_val = op_val[1];    assign u_if2.res_ready = res_ready[1];
    assign u_if4.op_val = op_val[2];    assign u_if4.res_ready = res_ready[2];
    assign u_if1.conj_en = conj_en;     assign u_if2.conj_en = conj_en;     assign u_if4.conj_en = conj_en;
    assign u_if1.op_1_re = a;           assign u_if2.op_1_re = a;           assign u_if4.op_1_re = a;
    assign u_if1.op_1_im = b;           assign u_if2.op_1_im = b;           assign u_if4.op_1_im = b;
    assign u_if1.op_2_re = c;           assign u_if2.op_2_re = c;           assign u_if4.op_2_re = c;
    assign u_if1.op_2_im = d;           assign u_if2.op_2_im = d;           assign u_if4.op_2_im = d;

    assign o_rv   = {u_if4.res_val,  u_if2.res_val,  u_if1.res_val};
    assign o_rdy  = {u_if4.op_ready, u_if2.op_ready, u_if1.op_ready};
    assign o_busy = {u_if4.busy,     u_if2.busy,     u_if1.busy};
    assign o_re[0] = u_if1.res_re;  assign o_im[0] = u_if1.res_im;
    assign o_re[1] = u_if2.res_re;  assign o_im[1] = u_if2.res_im;
    assign o_re[2] = u_if4.res_re;  assign o_im[2] = u_if4.res_im;

    complex_mult_param #(.DATA_WIDTH(DW), .NUM_MULT(1)) u_dut1 (.clk(clk), .sw_rst(sw_rst), .bus(u_if1));
    complex_mult_param #(.DATA_WIDTH(DW), .NUM_MULT(2)) u_dut2 (.clk(clk), .sw_rst(sw_rst), .bus(u_if2));
    complex_mult_param #(.DATA_WIDTH(DW), .NUM_MULT(4)) u_dut4 (.clk(clk), .sw_rst(sw_rst), .bus(u_if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected multiply-cycle count for instance n
    function automatic int kk(input int n);
        return (n == 0) ? 4 : (n == 1) ? 2 : 1;
    endfunction

    // Idle-to-result operation on instance n with res_ready=1.
    task automatic run_op(input int n, input int ia, input int ib, input int ic, input int id,
                          input logic cj, input int exp_re, input int exp_im, input string name);
        int cyc;
        a = DW'(ia); b = DW'(ib); c = DW'(ic); d = DW'(id); conj_en = cj;
        res_ready[n] = 1'b1;
        op_val[n] = 1'b1;
        #1;
        checks++;
        if (o_rdy[n] !== 1'b1) begin
            errors++; $display("FAIL %s[%0d] op_ready: got %b want 1", name, n, o_rdy[n]);
        end
        tick();
        op_val[n] = 1'b0;
        cyc = 1;
        while (o_rv[n] !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        checks++;
        if (o_rv[n] !== 1'b1) begin
            errors++; $display("FAIL %s[%0d] timeout: res_val never rose", name, n);
        end else if (cyc != kk(n) + 2) begin
            errors++; $display("FAIL %s[%0d] latency: got %0d want %0d", name, n, cyc, kk(n) + 2);
        end
        checks++;
        if (o_re[n] !== 17'(exp_re) || o_im[n] !== 17'(exp_im)) begin
            errors++; $display("FAIL %s[%0d] result: got %0d,%0d want %0d,%0d",
                               name, n, o_re[n], o_im[n], exp_re, exp_im);
        end
        tick();
        checks++;
        if (o_rv[n] !== 1'b0 || o_busy[n] !== 1'b0) begin
            errors++; $display("FAIL %s[%0d] one-cycle valid: got rv=%b busy=%b want 0,0",
                               name, n, o_rv[n], o_busy[n]);
        end
    endtask

    task automatic check_reset_state(input string name);
        for (int n = 0; n < 3; n++) begin
            checks++;
            if (o_rv[n] !== 1'b0 || o_busy[n] !== 1'b0 || o_rdy[n] !== 1'b1) begin
                errors++; $display("FAIL %s[%0d] ctrl: got rv=%b busy=%b rdy=%b want 0,0,1",
                                   name, n, o_rv[n], o_busy[n], o_rdy[n]);
            end
            checks++;
            if (o_re[n] !== 17'sd0 || o_im[n] !== 17'sd0) begin
                errors++; $display("FAIL %s[%0d] result: got %0d,%0d want 0,0",
                                   name, n, o_re[n], o_im[n]);
            end
        end
    endtask

    task automatic test_reset();
        sw_rst = 1'b1;
        tick();
        tick();
        sw_rst = 1'b0;
        check_reset_state("reset");
    endtask

    task automatic test_basic();
        for (int n = 0; n < 3; n++) run_op(n, 3, 4, 5, -2, 1'b0, 23, 14, "basic");
    endtask

    task automatic test_conj();
        for (int n = 0; n < 3; n++) run_op(n, 3, 4, 5, -2, 1'b1, 7, 26, "conj");
    endtask

    task automatic test_extremes();
        for (int n = 0; n < 3; n++) begin
            run_op(n, -128, -128, -128, -128, 1'b0, 0, 32768, "ext_mul");
            run_op(n, -128, -128, -128, -128, 1'b1, 32768, 0, "ext_conj");
            run_op(n, 127, -128, -128, 127, 1'b0, 0, 32513, "ext_mix");
        end
    endtask

    task automatic test_backpressure(input int n);
        int cyc;
        a = 8'sd3; b = 8'sd4; c = 8'sd5; d = -8'sd2; conj_en = 1'b0;
        res_ready[n] = 1'b0;
        op_val[n] = 1'b1;
        tick();
        op_val[n] = 1'b0;
        cyc = 1;
        while (o_rv[n] !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        checks++;
        if (o_rv[n] !== 1'b1) begin
            errors++; $display("FAIL bp[%0d] timeout: res_val never rose", n);
        end
        for (int i = 0; i < 5; i++) begin
            a = DW'(i * 37 + 1); b = DW'(i * 11 - 5); c = DW'(-i * 3); d = DW'(i + 9);
            conj_en = i[0];
            op_val[n] = ~i[0];
            #1;
            checks++;
            if (o_rv[n] !== 1'b1 || o_rdy[n] !== 1'b0 || o_busy[n] !== 1'b1) begin
                errors++; $display("FAIL bp[%0d] hold ctrl c%0d: got rv=%b rdy=%b busy=%b want 1,0,1",
                                   n, i, o_rv[n], o_rdy[n], o_busy[n]);
            end
            checks++;
            if (o_re[n] !== 17'sd23 || o_im[n] !== 17'sd14) begin
                errors++; $display("FAIL bp[%0d] hold data c%0d: got %0d,%0d want 23,14",
                                   n, i, o_re[n], o_im[n]);
            end
            tick();
        end
        op_val[n] = 1'b0;
        res_ready[n] = 1'b1;
        #1;
        checks++;
        if (o_rdy[n] !== 1'b1) begin
            errors++; $display("FAIL bp[%0d] release rdy: got %b want 1", n, o_rdy[n]);
        end
        tick();
        checks++;
        if (o_rv[n] !== 1'b0 || o_rdy[n] !== 1'b1 || o_busy[n] !== 1'b0) begin
            errors++; $display("FAIL bp[%0d] idle: got rv=%b rdy=%b busy=%b want 0,1,0",
                               n, o_rv[n], o_rdy[n], o_busy[n]);
        end
    endtask

    task automatic test_back_to_back(input int n);
        int cyc;
        a = 8'sd3; b = 8'sd4; c = 8'sd5; d = -8'sd2; conj_en = 1'b0;
        res_ready[n] = 1'b0;
        op_val[n] = 1'b1;
        tick();
        op_val[n] = 1'b0;
        cyc = 1;
        while (o_rv[n] !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        // Consume and issue on the same edge
        a = 8'sd1; b = 8'sd1; c = 8'sd1; d = -8'sd1;
        res_ready[n] = 1'b1;
        op_val[n] = 1'b1;
        #1;
        checks++;
        if (o_rv[n] !== 1'b1 || o_rdy[n] !== 1'b1 || o_re[n] !== 17'sd23 || o_im[n] !== 17'sd14) begin
            errors++; $display("FAIL b2b[%0d] overlap: got rv=%b rdy=%b res=%0d,%0d want 1,1,23,14",
                               n, o_rv[n], o_rdy[n], o_re[n], o_im[n]);
        end
        tick();
        op_val[n] = 1'b0;
        checks++;
        if (o_rv[n] !== 1'b0 || o_busy[n] !== 1'b1) begin
            errors++; $display("FAIL b2b[%0d] no bubble: got rv=%b busy=%b want 0,1", n, o_rv[n], o_busy[n]);
        end
        cyc = 1;
        while (o_rv[n] !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        checks++;
        if (o_rv[n] !== 1'b1 || cyc != kk(n) + 2) begin
            errors++; $display("FAIL b2b[%0d] latency: got rv=%b cyc=%0d want 1,%0d", n, o_rv[n], cyc, kk(n) + 2);
        end
        checks++;
        if (o_re[n] !== 17'sd2 || o_im[n] !== 17'sd0) begin
            errors++; $display("FAIL b2b[%0d] result: got %0d,%0d want 2,0", n, o_re[n], o_im[n]);
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        a = 8'sd5; b = 8'sd5; c = 8'sd7; d = 8'sd7; conj_en = 1'b1;
        op_val[0] = 1'b1;
        tick();                 // handshake edge; now first MULT cycle
        op_val[0] = 1'b0;
        tick();                 // second MULT cycle
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        check_reset_state("rst_mid");
        for (int n = 0; n < 3; n++) run_op(n, 2, 0, 0, 3, 1'b0, 0, 6, "post_rst");
    endtask

    initial begin
        sw_rst = 1'b0;
        op_val = 3'b000;
        res_ready = 3'b111;
        conj_en = 1'b0;
        a = '0; b = '0; c = '0; d = '0;
        test_reset();
        test_basic();
        test_conj();
        test_extremes();
        for (int n = 0; n < 3; n++) test_backpressure(n);
        for (int n = 0; n < 3; n++) test_back_to_back(n);
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
